// File: rtl/muldiv_unit_if.sv
// Request/response bundle for the iterative multiply/divide unit.
// The master (control FSM) drives start/op/a/b; the slave (muldiv_unit)
// returns busy/done/result/err.
interface muldiv_unit_if #(
    parameter int DBITS = 32
) ();
    logic             start;
    logic [2:0]       op;
    logic [DBITS-1:0] a;
    logic [DBITS-1:0] b;
    logic             busy;
    logic             done;
    logic [DBITS-1:0] result;
    logic             err;

    modport master (
        output start, op, a, b,
        input  busy, done, result, err
    );

    modport slave (
        input  start, op, a, b,
        output busy, done, result, err
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative radix-2 multiply/divide unit: MUL/MULH/MULHU/DIV/DIVU/REM/REMU.
// One shift-add (multiply) or restoring shift-subtract (divide) step per clock,
// operating on magnitudes with a final sign fix in the FIX state.
// Optional feature macro: MULDIV_DIV_EN -- when defined the divide datapath is
// built; when undefined, ops 1xx take the reserved-op path (result 0, err 1).
module muldiv_unit #(
    parameter int DBITS   = 32,
    parameter int CNTBITS = $clog2(DBITS + 1)
) (
    input  logic         clk,
    input  logic         reset,
    muldiv_unit_if.slave bus
);
    localparam logic [DBITS-1:0]   ONE_D = DBITS'(1);
    localparam logic [2*DBITS-1:0] ONE_P = (2*DBITS)'(1);

    localparam logic [2:0] OP_MUL   = 3'b000;
    localparam logic [2:0] OP_MULH  = 3'b001;
    localparam logic [2:0] OP_MULHU = 3'b010;
    localparam logic [2:0] OP_RSV   = 3'b011;
`ifdef MULDIV_DIV_EN
    localparam logic [2:0] OP_DIV   = 3'b100;
    localparam logic [2:0] OP_DIVU  = 3'b101;
    localparam logic [2:0] OP_REM   = 3'b110;
    localparam logic [2:0] OP_REMU  = 3'b111;
`endif

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t             state;
    state_t             state_nx;

    logic               accept;
    logic               signed_in;
    logic               reserved_in;
    logic [DBITS-1:0]   a_abs;
    logic [DBITS-1:0]   b_abs;

    logic [2:0]         op_r;
    logic [DBITS-1:0]   opa;
    logic [DBITS-1:0]   opb;
    logic [2*DBITS-1:0] acc;
    logic [2*DBITS-1:0] acc_step;
    logic [CNTBITS-1:0] cnt;
    logic               neg_q;
    logic               rsv;

    logic [2*DBITS-1:0] prod;
    logic [DBITS-1:0]   fix_result;
    logic               fix_err;
    logic [DBITS-1:0]   result_r;
    logic               err_r;

`ifdef MULDIV_DIV_EN
    logic               neg_r;
    logic               dz;
    logic [DBITS:0]     trial;
    logic [DBITS-1:0]   rem_sub;
    logic               ge;
    logic [DBITS-1:0]   quo;
    logic [DBITS-1:0]   rem;
`endif

    assign accept     = bus.start && (state == IDLE || state == DONE);
    assign bus.result = result_r;
    assign bus.err    = err_r;

    // Decode the incoming request: signedness, reserved path, operand magnitudes.
    always_comb begin
        signed_in   = (bus.op == OP_MULH);
        reserved_in = (bus.op == OP_RSV);
`ifdef MULDIV_DIV_EN
        signed_in   = signed_in || (bus.op == OP_DIV) || (bus.op == OP_REM);
`else
        reserved_in = reserved_in || bus.op[2];
`endif
        a_abs = (signed_in && bus.a[DBITS-1]) ? ~bus.a + ONE_D : bus.a;
        b_abs = (signed_in && bus.b[DBITS-1]) ? ~bus.b + ONE_D : bus.b;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state and status outputs.
    always_comb begin
        state_nx = state;
        bus.busy = 1'b0;
        bus.done = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nx = reserved_in ? FIX : CALC;
                end
            end
            CALC: begin
                bus.busy = 1'b1;
                if (cnt == CNTBITS'(1)) begin
                    state_nx = FIX;
                end
            end
            FIX: begin
                bus.busy = 1'b1;
                state_nx = DONE;
            end
            DONE: begin
                bus.done = 1'b1;
                if (accept) begin
                    state_nx = reserved_in ? FIX : CALC;
                end else begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // One iteration: MSB-first shift-add for multiply; restoring divide builds
    // the remainder in acc[hi] and shifts quotient bits into acc[lo].
    always_comb begin
        acc_step = {acc[2*DBITS-2:0], 1'b0} + (opb[DBITS-1] ? {{DBITS{1'b0}}, opa} : '0);
`ifdef MULDIV_DIV_EN
        trial   = {acc[2*DBITS-1:DBITS], opa[DBITS-1]};
        rem_sub = trial[DBITS-1:0] - opb;
        ge      = (trial >= {1'b0, opb});
        if (op_r[2]) begin
            acc_step = {(ge ? rem_sub : trial[DBITS-1:0]), acc[DBITS-2:0], ge};
        end
`endif
    end

    // Sign correction and output-word selection used in the FIX state.
    always_comb begin
        prod       = neg_q ? ~acc + ONE_P : acc;
        fix_result = '0;
        fix_err    = rsv;
`ifdef MULDIV_DIV_EN
        quo     = acc[DBITS-1:0];
        rem     = acc[2*DBITS-1:DBITS];
        fix_err = rsv || dz;
`endif
        case (op_r)
            OP_MUL:            fix_result = prod[DBITS-1:0];
            OP_MULH, OP_MULHU: fix_result = prod[2*DBITS-1:DBITS];
`ifdef MULDIV_DIV_EN
            OP_DIV, OP_DIVU:   fix_result = dz ? '1 : (neg_q ? ~quo + ONE_D : quo);
            OP_REM, OP_REMU:   fix_result = neg_r ? ~rem + ONE_D : rem;
`endif
            default:           fix_result = '0;
        endcase
    end

    // Operand latch, iteration datapath and registered result.
    always_ff @(posedge clk) begin
        if (reset) begin
            op_r     <= '0;
            opa      <= '0;
            opb      <= '0;
            acc      <= '0;
            cnt      <= '0;
            neg_q    <= 1'b0;
            rsv      <= 1'b0;
            result_r <= '0;
            err_r    <= 1'b0;
`ifdef MULDIV_DIV_EN
            neg_r    <= 1'b0;
            dz       <= 1'b0;
`endif
        end else if (accept) begin
            op_r  <= bus.op;
            opa   <= a_abs;
            opb   <= b_abs;
            acc   <= '0;
            cnt   <= reserved_in ? '0 : CNTBITS'(DBITS);
            neg_q <= signed_in && (bus.a[DBITS-1] ^ bus.b[DBITS-1]);
            rsv   <= reserved_in;
`ifdef MULDIV_DIV_EN
            neg_r <= signed_in && bus.a[DBITS-1];
            dz    <= bus.op[2] && (bus.b == '0);
`endif
        end else if (state == CALC) begin
            cnt <= cnt - CNTBITS'(1);
            acc <= acc_step;
`ifdef MULDIV_DIV_EN
            if (op_r[2]) begin
                opa <= {opa[DBITS-2:0], 1'b0};
            end else begin
                opb <= {opb[DBITS-2:0], 1'b0};
            end
`else
            opb <= {opb[DBITS-2:0], 1'b0};
`endif
        end else if (state == FIX) begin
            result_r <= fix_result;
            err_r    <= fix_err;
        end
    end
endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative multiply/divide execution unit for the multicycle bus-based processor. It extends the single-cycle ALU with MUL/MULH/MULHU/DIV/DIVU/REM/REMU. The control FSM loads the operands from the A/B registers, pulses `start`, and waits for `done` before driving `result` onto the bus. It is generalised over data width, uses one radix-2 iteration per clock, and handles signed and unsigned operations in one datapath.

## Interface
- `DBITS`, 32: operand/result width; legal range 4..64.
- `CNTBITS`, $clog2(DBITS+1): iteration counter width; derived, do not override.

- `clk`  in  1  processor clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  request; sampled only when `busy`=0.
- `op`  in  3  000 MUL (low word), 001 MULH (signed×signed high word), 010 MULHU (unsigned high word), 011 reserved, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `a`  in  DBITS  dividend/multiplicand; sampled with `start`.
- `b`  in  DBITS  divisor/multiplier; sampled with `start`.
- `busy`  out  1  high in the CALC and FIX states.
- `done`  out  1  one-cycle pulse; `result` and `err` are valid in that cycle.
- `result`  out  DBITS  registered; held until the next accepted `start`.
- `err`  out  1  registered; set for divide-by-zero, reserved `op`, or divide op with divide compiled out.

## Operation
- States: IDLE, CALC, FIX, DONE.
- Clock, reset and synchronicity: one clock; reset is synchronous and active-high (name the clock and reset ports as the codebase does; the polarity and synchronicity here are fixed).
- Reset values: state IDLE, `busy`=0, `done`=0, `result`=0, `err`=0, counter 0.
- `start` is accepted in IDLE or DONE. On accept:
  - latch `op`;
  - latch |a|, |b| for signed ops, raw values for unsigned ops;
  - latch the result-sign bits;
  - clear the 2·DBITS accumulator;
  - set the counter to DBITS;
  - go to CALC.
- Without a new `start`, DONE always returns to IDLE.
- CALC performs one shift-add (multiply) or restoring shift-subtract (divide) step per cycle. It decrements the counter and moves to FIX when the counter reaches 0.
- FIX applies the sign correction, selects the output word and registers `result`/`err`, then goes to DONE.
- Sign rules:
  - MUL: low word; identical for signed and unsigned.
  - MULH: negate the 2·DBITS product iff a[MSB]^b[MSB].
  - Quotient: negate iff a[MSB]^b[MSB].
  - Remainder: takes the sign of `a`.
- Divide by zero (b==0, any divide op): quotient all-ones, remainder = `a`, `err`=1. Latency is unchanged.
- Signed overflow (a = most-negative, b = −1): quotient = most-negative, remainder 0, `err`=0.
- Reserved op 011: no CALC. Go IDLE→FIX→DONE with `result`=0 and `err`=1.
- `start` while `busy`=1 is ignored; the operation in flight is unaffected.
- `reset` in any state aborts the operation. Outputs return to reset values on that edge and no `done` is generated.

## Timing
- `start` high in cycle 0 (IDLE) → CALC in cycles 1..DBITS → FIX in cycle DBITS+1 → `done` in cycle DBITS+2. For DBITS=32, `done` is in cycle 34.
- Reserved op, or divide op with divide compiled out: `done` in cycle 2.
- Back-to-back: `start` during the DONE cycle is accepted. The next `done` follows DBITS+2 cycles later, with no idle bubble.
- `result`/`err` change only on FIX-state edges and reset.

## Configuration
- `MULDIV_DIV_EN` defined:
  - the divide datapath (remainder register, subtract/compare, quotient/remainder sign fix) is compiled in;
  - ops 100–111 behave as above.
- `MULDIV_DIV_EN` undefined:
  - no divide hardware is built;
  - ops 1xx take the reserved-op path: `result`=0, `err`=1, `done` in cycle 2;
  - multiply behaviour and latency are unchanged.

## Test plan
- MUL a=7, b=0xFFFFFFFD (−3), DBITS=32:
  - `done` exactly in cycle 34, `result`=0xFFFFFFEB, `err`=0;
  - `busy` high in cycles 1–33.
- High-word multiply, each in its own run:
  - MULH a=b=0x80000000 → 0x40000000;
  - MULHU a=b=0xFFFFFFFF → 0xFFFFFFFE.
- Signed divide, a=0xFFFFFFF9 (−7), b=2:
  - DIV → 0xFFFFFFFD;
  - REM → 0xFFFFFFFF;
  - DIV a=0x80000000, b=0xFFFFFFFF → 0x80000000, `err`=0.
- Divide by zero, b=0, each in its own run:
  - DIVU a=5 → 0xFFFFFFFF, `err`=1;
  - REMU a=5 → 5, `err`=1;
  - `done` in cycle 34 in both runs.
- Flow control:
  - `start` with a new op at cycle 10 of a MUL is ignored and the original result is returned;
  - `start` in the DONE cycle is accepted and the next `done` is 34 cycles later;
  - op 011 → `result`=0, `err`=1, `done` in cycle 2.
- Reset in cycle 15 of a DIV:
  - `busy`=0, `result`=0, `err`=0 on that edge;
  - no `done` within the following 40 cycles.
  - Repeat all divide cases with `MULDIV_DIV_EN` undefined: `done` in cycle 2, `result`=0, `err`=1.
